// File: rtl/thermo_pkg.sv
// Shared types and defaults for the thermostat request generator.
package thermo_pkg;

  localparam int unsigned DEF_W           = 8;
  localparam int unsigned DEF_THRESH      = 2;
  localparam int unsigned DEF_MIN_RUN     = 4;
  localparam int unsigned DEF_LOCKOUT     = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAT    = 3'd1,
    COOL    = 3'd2,
    HOLDOFF = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // LED pair returned by the air-conditioning unit
  typedef struct packed {
    logic lr;
    logic lg;
  } led_t;

  localparam led_t LED_OFF  = '{lr: 1'b0, lg: 1'b0};
  localparam led_t LED_HEAT = '{lr: 1'b1, lg: 1'b0};
  localparam led_t LED_COOL = '{lr: 1'b0, lg: 1'b1};

  // LED pair the unit should show once it has followed the request of state s
  function automatic led_t expected_led(input state_t s);
    case (s)
      HEAT:    return LED_HEAT;
      COOL:    return LED_COOL;
      default: return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive cycles where the unit LEDs disagree with the expected pair;
// flags a timeout on the cycle the count would reach the limit.
module ack_watchdog
  import thermo_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  led_t expected,
  input  led_t leds,
  output logic timeout_c
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          mismatch_c;

  assign mismatch_c = (leds != expected);

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !mismatch_c) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout_c = mismatch_c && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/thermostat_ctrl.sv
// Heat/cool request FSM with hysteresis, minimum run, lockout and an
// acknowledge watchdog on the unit's LEDs.
module thermostat_ctrl
  import thermo_pkg::*;
#(
  parameter int unsigned W           = DEF_W,
  parameter int unsigned THRESH      = DEF_THRESH,
  parameter int unsigned MIN_RUN     = DEF_MIN_RUN,
  parameter int unsigned LOCKOUT     = DEF_LOCKOUT,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [W-1:0] target,
  input  logic [W-1:0] ambient,
  input  logic         sample_valid,
  input  logic         LR,
  input  logic         LG,
  output logic         A,
  output logic         B,
  output logic         status,
  output logic         fault
);

  localparam int unsigned WX = W + 1;
  localparam int unsigned RW = $clog2(MIN_RUN + 1);
  localparam int unsigned HW = $clog2(LOCKOUT + 1);

  state_t        state;
  state_t        state_next;
  state_t        next_pre;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_inc_c;
  logic [HW-1:0] hold_cnt;
  logic [WX-1:0] amb_x;
  logic [WX-1:0] tgt_x;
  logic          heat_need_c;
  logic          cool_need_c;
  logic          amb_lt_tgt_c;
  logic          amb_gt_tgt_c;
  logic          run_done_c;
  logic          leds_illegal_c;
  logic          wd_clear_c;
  logic          wd_timeout_c;
  led_t          leds_c;

  // Widened compares so that +THRESH can never wrap at the code limits
  assign amb_x        = {1'b0, ambient};
  assign tgt_x        = {1'b0, target};
  assign heat_need_c  = (amb_x + WX'(THRESH)) < tgt_x;
  assign cool_need_c  = amb_x > (tgt_x + WX'(THRESH));
  assign amb_lt_tgt_c = ambient < target;
  assign amb_gt_tgt_c = ambient > target;

  // Run count including the current sample, saturating at MIN_RUN
  assign run_inc_c  = (run_cnt == RW'(MIN_RUN)) ? run_cnt : run_cnt + RW'(1);
  assign run_done_c = (run_inc_c == RW'(MIN_RUN));

  assign leds_c         = '{lr: LR, lg: LG};
  assign leds_illegal_c = LR & LG;

  ack_watchdog #(
    .TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clock    (clock),
    .rst      (rst),
    .clear    (wd_clear_c),
    .expected (expected_led(state)),
    .leds     (leds_c),
    .timeout_c(wd_timeout_c)
  );

  // Watchdog restarts on every ordinary state change; FAULT needs no watching
  assign wd_clear_c = (next_pre != state) || (state == FAULT);

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next_pre is the regular flow; fault detection overrides it afterwards
  always_comb begin
    next_pre   = state;
    state_next = state;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          if (heat_need_c) begin
            next_pre = HEAT;
          end else if (cool_need_c) begin
            next_pre = COOL;
          end
        end
      end
      HEAT: begin
        if (sample_valid && !amb_lt_tgt_c && run_done_c) begin
          next_pre = HOLDOFF;
        end
      end
      COOL: begin
        if (sample_valid && !amb_gt_tgt_c && run_done_c) begin
          next_pre = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == HW'(LOCKOUT - 1)) begin
          next_pre = IDLE;
        end
      end
      FAULT: begin
        next_pre = FAULT;
      end
      default: begin
        next_pre = IDLE;
      end
    endcase
    state_next = next_pre;
    if ((state != FAULT) && (leds_illegal_c || wd_timeout_c)) begin
      state_next = FAULT;
    end
  end

  // Registered outputs and run/holdoff counters
  always_ff @(posedge clock) begin
    if (rst) begin
      A        <= 1'b0;
      B        <= 1'b0;
      status   <= 1'b0;
      fault    <= 1'b0;
      run_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      A     <= (state_next == HEAT);
      B     <= (state_next == COOL);
      fault <= (state_next == FAULT);
      if (sample_valid && (state != FAULT)) begin
        status <= amb_lt_tgt_c;
      end
      if (state_next != state) begin
        run_cnt <= '0;
      end else if (sample_valid && ((state == HEAT) || (state == COOL))) begin
        run_cnt <= run_inc_c;
      end
      if ((state != HOLDOFF) || (state_next != HOLDOFF)) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Scoreboard bench for thermostat_ctrl with a one-edge-lag air-conditioning unit model.
module tb_thermostat_ctrl;

  logic       clock;
  logic       rst;
  logic [7:0] target;
  logic [7:0] ambient;
  logic       sample_valid;
  logic       LR;
  logic       LG;
  logic       A;
  logic       B;
  logic       status;
  logic       fault;

  logic use_model;
  logic force_lr;
  logic force_lg;
  logic unit_lr;
  logic unit_lg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] v;   // {A, B, status, fault}
  } exp_t;

  exp_t sb[$];

  thermostat_ctrl dut (
    .clock       (clock),
    .rst         (rst),
    .target      (target),
    .ambient     (ambient),
    .sample_valid(sample_valid),
    .LR          (LR),
    .LG          (LG),
    .A           (A),
    .B           (B),
    .status      (status),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unit registers the request one edge after the controller
  always_ff @(posedge clock) begin
    if (rst) begin
      unit_lr <= 1'b0;
      unit_lg <= 1'b0;
    end else begin
      unit_lr <= A;
      unit_lg <= B;
    end
  end

  assign LR = use_model ? unit_lr : force_lr;
  assign LG = use_model ? unit_lg : force_lg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push its expected outputs, compare after the edge
  task automatic step(input logic sv, input logic [7:0] amb, input logic [7:0] tgt,
                      input logic [3:0] exp, input string tag);
    exp_t e;
    sample_valid = sv;
    ambient      = amb;
    target       = tgt;
    sb.push_back('{tag: tag, v: exp});
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, 32'({A, B, status, fault}), 32'(e.v));
    end
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    use_model = 1'b0;
    force_lr  = 1'b0;
    force_lg  = 1'b0;
    step(1'b0, 8'd0, 8'd0, 4'b0000, tag);
    rst       = 1'b0;
    use_model = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    target       = 8'd0;
    ambient      = 8'd0;
    sample_valid = 1'b0;
    use_model    = 1'b0;
    force_lr     = 1'b0;
    force_lg     = 1'b0;
    #1;

    do_reset("reset");
    step(1'b0, 8'd60, 8'd70, 4'b0000, "no_strobe");

    // Heat cycle, minimum run, exact lockout length
    step(1'b1, 8'd60, 8'd70, 4'b1010, "heat_entry");
    step(1'b0, 8'd60, 8'd70, 4'b1010, "heat_ack");
    for (int i = 0; i < 3; i++) step(1'b1, 8'd70, 8'd70, 4'b1000, "heat_run");
    step(1'b1, 8'd70, 8'd70, 4'b0000, "heat_release");
    for (int i = 0; i < 4; i++) step(1'b1, 8'd60, 8'd70, 4'b0010, "holdoff_ignore");
    step(1'b1, 8'd60, 8'd70, 4'b1010, "reheat");
    step(1'b0, 8'd60, 8'd70, 4'b1010, "reheat_ack");
    for (int i = 0; i < 3; i++) step(1'b1, 8'd75, 8'd70, 4'b1000, "reheat_run");
    step(1'b1, 8'd75, 8'd70, 4'b0000, "reheat_release");
    for (int i = 0; i < 5; i++) step(1'b0, 8'd75, 8'd70, 4'b0000, "idle_wait");

    // Hysteresis edges, then cool with an early-release attempt
    step(1'b1, 8'd68, 8'd70, 4'b0010, "hyst_low");
    step(1'b1, 8'd72, 8'd70, 4'b0000, "hyst_high");
    step(1'b1, 8'd73, 8'd70, 4'b0100, "cool_entry");
    step(1'b1, 8'd73, 8'd70, 4'b0100, "cool_s1");
    step(1'b1, 8'd60, 8'd70, 4'b0110, "cool_s2_early");
    step(1'b1, 8'd60, 8'd70, 4'b0110, "cool_s3");
    step(1'b1, 8'd60, 8'd70, 4'b0010, "cool_release");
    for (int i = 0; i < 5; i++) step(1'b0, 8'd60, 8'd70, 4'b0010, "cool_holdoff");

    // Reset in the middle of a cool run
    step(1'b1, 8'd80, 8'd70, 4'b0100, "cool_again");
    step(1'b0, 8'd80, 8'd70, 4'b0100, "cool_hold");
    do_reset("rst_mid_cool");
    step(1'b0, 8'd80, 8'd70, 4'b0000, "post_rst");
    step(1'b1, 8'd60, 8'd70, 4'b1010, "post_rst_idle");
    do_reset("rst2");

    // Code-limit corners
    step(1'b1, 8'd255, 8'd255, 4'b0000, "max_max");
    step(1'b1, 8'd0,   8'd0,   4'b0000, "zero_zero");
    step(1'b1, 8'd252, 8'd255, 4'b1010, "max_heat");
    do_reset("rst3");

    // Watchdog: unit never acknowledges
    use_model = 1'b0;
    step(1'b1, 8'd60, 8'd70, 4'b1010, "wd_entry");
    step(1'b0, 8'd60, 8'd70, 4'b1010, "wd_1");
    step(1'b0, 8'd60, 8'd70, 4'b1010, "wd_2");
    step(1'b0, 8'd60, 8'd70, 4'b0011, "wd_fault");
    step(1'b1, 8'd90, 8'd70, 4'b0011, "fault_sticky");
    step(1'b1, 8'd60, 8'd70, 4'b0011, "fault_sticky2");
    do_reset("rst4");

    // Both LEDs lit in IDLE
    use_model = 1'b0;
    force_lr  = 1'b1;
    force_lg  = 1'b1;
    step(1'b0, 8'd70, 8'd70, 4'b0001, "illegal_leds");
    force_lr  = 1'b0;
    force_lg  = 1'b0;
    step(1'b0, 8'd70, 8'd70, 4'b0001, "illegal_sticky");
    do_reset("rst_final");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
